// File: rtl/definitions_pkg.sv
// Shared compute-group and control-write FIFO sizing constants.
// Also defines the packed store entry type and a helper for the beat-count width.
package definitions_pkg;

  localparam int unsigned COMPUTING_GROUP_SIZE = 2;
  localparam int unsigned FEATURE_BIT_SIZE     = 8;
  localparam int unsigned WRITE_FIFO_SIZE      = 4;
  localparam int unsigned CTRLWRITE_PACK_RATIO = 2;

  localparam int unsigned CTRLWRITE_IN_W  = COMPUTING_GROUP_SIZE * FEATURE_BIT_SIZE;
  localparam int unsigned CTRLWRITE_OUT_W = CTRLWRITE_PACK_RATIO * CTRLWRITE_IN_W;

  function automatic int unsigned beat_cnt_w(input int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction

  localparam int unsigned CTRLWRITE_BCNT_W = beat_cnt_w(CTRLWRITE_PACK_RATIO);

  // One store entry at the default sizing: beat count above the packed word.
  typedef struct packed {
    logic [CTRLWRITE_BCNT_W-1:0] beats;
    logic [CTRLWRITE_OUT_W-1:0]  data;
  } ctrlwrite_entry_t;

endpackage

// File: rtl/fifo_ctrlwrite_store.sv
// Circular word store with arbitrary depth (explicit pointer wrap), occupancy count,
// and either first-word-fall-through or registered read data.
module fifo_ctrlwrite_store
  import definitions_pkg::*;
#(
  parameter int unsigned WIDTH = CTRLWRITE_BCNT_W + CTRLWRITE_OUT_W,
  parameter int unsigned DEPTH = WRITE_FIFO_SIZE + 1,
  parameter bit          FWFT  = 1'b1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Masked while empty so the unreset memory never leaks onto the outputs.
      assign rdata = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (srst) begin
          rdata_q <= '0;
        end else if (pop) begin
          rdata_q <= mem[rd_ptr];
        end
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: rtl/fifo_ctrlwrite_pack.sv
// Control-write FIFO: packs RATIO compute-group beats into one wide word (early close
// on din_last) and buffers words in a DEPTH-entry store with prog_full and sticky error flags.
module fifo_ctrlwrite_pack
  import definitions_pkg::*;
#(
  parameter int unsigned LANES = COMPUTING_GROUP_SIZE,
  parameter int unsigned ELEM_W = FEATURE_BIT_SIZE,
  parameter int unsigned RATIO = CTRLWRITE_PACK_RATIO,
  parameter int unsigned DEPTH = WRITE_FIFO_SIZE + 1,
  parameter bit          FWFT  = 1'b1,
  localparam int unsigned IN_W   = LANES * ELEM_W,
  localparam int unsigned OUT_W  = RATIO * IN_W,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
  localparam int unsigned BCNT_W = beat_cnt_w(RATIO)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [IN_W-1:0]   din,
  input  logic              din_last,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [CNT_W-1:0]  prog_thresh,
  output logic [OUT_W-1:0]  dout,
  output logic [BCNT_W-1:0] dout_beats,
  output logic              full,
  output logic              empty,
  output logic              prog_full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  logic [BCNT_W-1:0] beat_q;
  logic [OUT_W-1:0]  pack_q;
  logic [OUT_W-1:0]  pack_next;
  logic              accept;
  logic              close;
  logic              pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign prog_full = (count >= prog_thresh);
  assign accept    = wr_en && !full;
  assign pop       = rd_en && !empty;
  assign close     = (beat_q == BCNT_W'(RATIO - 1)) || din_last;

  always_comb begin
    pack_next = pack_q;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (BCNT_W'(i) == beat_q) begin
        pack_next[i*IN_W +: IN_W] = din;
      end
    end
  end

  // The pack register is cleared on every push so unfilled slices of an early-closed word are zero.
  always_ff @(posedge clk) begin
    if (srst) begin
      pack_q    <= '0;
      beat_q    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (accept) begin
        if (close) begin
          pack_q <= '0;
          beat_q <= '0;
        end else begin
          pack_q <= pack_next;
          beat_q <= beat_q + BCNT_W'(1);
        end
      end
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  fifo_ctrlwrite_store #(
    .WIDTH (BCNT_W + OUT_W),
    .DEPTH (DEPTH),
    .FWFT  (FWFT)
  ) u_store (
    .clk   (clk),
    .srst  (srst),
    .push  (accept && close),
    .wdata ({beat_q + BCNT_W'(1), pack_next}),
    .pop   (pop),
    .rdata ({dout_beats, dout}),
    .count (count),
    .empty (empty)
  );

endmodule

// File: tb/tb_fifo_ctrlwrite_pack.sv
// Randomized scoreboard bench: one FWFT and one registered-read instance share stimulus,
// expected words come from a queue-based packing model and are popped by a monitor.
module tb_fifo_ctrlwrite_pack;

  localparam int DEPTH = 5;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  b;
  } ent_t;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [15:0] din = '0;
  logic        din_last = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [2:0]  prog_thresh = 3'd0;

  logic [31:0] dout1, dout0;
  logic [1:0]  beats1, beats0;
  logic        full1, full0, empty1, empty0, pf1, pf0, of1, of0, uf1, uf0;
  logic [2:0]  count1, count0;

  int total = 0;
  int bad = 0;

  ent_t        sb1[$];
  ent_t        sb0[$];
  logic [15:0] mh[$];
  int          mcount = 0;
  bit          m_of = 0, m_uf = 0;
  bit          rst_prev = 0;

  always #5 clk = ~clk;

  fifo_ctrlwrite_pack #(
    .LANES(2), .ELEM_W(8), .RATIO(2), .DEPTH(DEPTH), .FWFT(1'b1)
  ) dut1 (
    .clk(clk), .srst(srst), .din(din), .din_last(din_last), .wr_en(wr_en),
    .rd_en(rd_en), .prog_thresh(prog_thresh), .dout(dout1), .dout_beats(beats1),
    .full(full1), .empty(empty1), .prog_full(pf1), .count(count1),
    .overflow(of1), .underflow(uf1)
  );

  fifo_ctrlwrite_pack #(
    .LANES(2), .ELEM_W(8), .RATIO(2), .DEPTH(DEPTH), .FWFT(1'b0)
  ) dut0 (
    .clk(clk), .srst(srst), .din(din), .din_last(din_last), .wr_en(wr_en),
    .rd_en(rd_en), .prog_thresh(prog_thresh), .dout(dout0), .dout_beats(beats0),
    .full(full0), .empty(empty0), .prog_full(pf0), .count(count0),
    .overflow(of0), .underflow(uf0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("count_fwft", 64'(count1), 64'(mcount));
    chk("count_reg", 64'(count0), 64'(mcount));
    chk("empty_fwft", 64'(empty1), 64'(mcount == 0));
    chk("empty_reg", 64'(empty0), 64'(mcount == 0));
    chk("full_fwft", 64'(full1), 64'(mcount == DEPTH));
    chk("full_reg", 64'(full0), 64'(mcount == DEPTH));
    chk("prog_full", 64'(pf1), 64'(mcount >= int'(prog_thresh)));
    chk("prog_full_reg", 64'(pf0), 64'(mcount >= int'(prog_thresh)));
    chk("overflow", 64'({of1, of0}), 64'({m_of, m_of}));
    chk("underflow", 64'({uf1, uf0}), 64'({m_uf, m_uf}));
    if (sb1.size() > 0) begin
      chk("head_dout", 64'(dout1), 64'(sb1[0].d));
      chk("head_beats", 64'(beats1), 64'(sb1[0].b));
    end
    if (rst_prev) begin
      chk("reset_dout", 64'(dout1), 64'd0);
      chk("reset_beats", 64'(beats1), 64'd0);
    end
  endtask

  // One clock of stimulus: check state left by earlier edges, then drive and model the next edge.
  task automatic step(input bit w, input logic [15:0] d, input bit l, input bit r, input bit rst);
    logic [31:0] word;
    ent_t        e;
    bit          acc_w, acc_r;
    @(negedge clk);
    #1;
    check_state();
    srst = rst; wr_en = w; din = d; din_last = l; rd_en = r;
    rst_prev = rst;
    if (rst) begin
      mcount = 0; mh.delete(); m_of = 0; m_uf = 0;
    end else begin
      acc_w = w && (mcount < DEPTH);
      acc_r = r && (mcount > 0);
      if (w && !acc_w) m_of = 1;
      if (r && mcount == 0) m_uf = 1;
      if (acc_w) begin
        mh.push_back(d);
        if (mh.size() == 2 || l) begin
          word = '0;
          for (int i = 0; i < mh.size(); i++) word[i*16 +: 16] = mh[i];
          e.d = word;
          e.b = 2'(mh.size());
          sb1.push_back(e);
          sb0.push_back(e);
          mh.delete();
          mcount++;
        end
      end
      if (acc_r) mcount--;
    end
  endtask

  // Monitor: compares words as each DUT presents them on an accepted read.
  initial begin
    bit          armed = 0;
    bit          pend0 = 0;
    logic [31:0] hd = '0;
    logic [1:0]  hb = '0;
    ent_t        e;
    forever begin
      @(negedge clk);
      #3;
      if (armed) begin
        if (pend0) begin
          if (sb0.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_reg_unexpected: got %0h expected no word", dout0);
          end else begin
            e = sb0.pop_front();
            chk("rd_reg_dout", 64'(dout0), 64'(e.d));
            chk("rd_reg_beats", 64'(beats0), 64'(e.b));
            hd = e.d; hb = e.b;
          end
        end else begin
          chk("hold_reg_dout", 64'(dout0), 64'(hd));
          chk("hold_reg_beats", 64'(beats0), 64'(hb));
        end
        if (!srst && rd_en && !empty1) begin
          if (sb1.size() == 0) begin
            total++; bad++;
            $display("FAIL rd_fwft_unexpected: got %0h expected no word", dout1);
          end else begin
            e = sb1.pop_front();
            chk("rd_fwft_dout", 64'(dout1), 64'(e.d));
            chk("rd_fwft_beats", 64'(beats1), 64'(e.b));
          end
        end
      end
      pend0 = !srst && rd_en && !empty0;
      if (srst) begin
        armed = 1; pend0 = 0; hd = '0; hb = '0;
        sb0.delete(); sb1.delete();
      end
    end
  end

  initial begin
    step(0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 0, 0, 1);
    prog_thresh = 3'd4;
    // two full beats, then an early-closed word, then a fresh word from slice 0
    step(1, 16'h1111, 0, 0, 0);
    step(1, 16'h2222, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    step(1, 16'hAAAA, 1, 0, 0);
    step(1, 16'h1234, 0, 0, 0);
    step(1, 16'h5678, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    repeat (3) step(0, 16'h0, 0, 1, 0);
    // fill to full, then one dropped beat
    for (int i = 0; i < 11; i++) step(1, 16'h0100 + 16'(i), 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    // drain with interleaved pushes across the pointer wrap
    for (int i = 0; i < 8; i++) step(i >= 2, 16'h0200 + 16'(i), 0, i < 5, 0);
    step(0, 16'h0, 0, 0, 0);
    repeat (3) step(0, 16'h0, 0, 1, 0);
    step(0, 16'h0, 0, 1, 0);
    step(0, 16'h0, 0, 0, 0);
    // reset with one beat held: it must never surface
    step(1, 16'hBEEF, 0, 0, 0);
    step(0, 16'h0, 0, 0, 1);
    prog_thresh = 3'd0;
    step(1, 16'h0001, 0, 0, 0);
    step(1, 16'h0002, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 0, 1, 0);
    step(0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (i % 37 == 0) prog_thresh = 3'($urandom_range(0, 6));
      step(($urandom % 100) < 60, 16'($urandom), ($urandom % 4) == 0,
           ($urandom % 100) < 45, ($urandom % 100) == 0);
    end
    step(0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrlwrite_pack.md
Name: fifo_ctrlwrite_pack

Overview:
- Next-generation control-write data FIFO. Accepts computing-group result beats (LANES x ELEM_W) and packs RATIO beats into one wide write word.
- Buffers packed words in a DEPTH-entry circular store; DEPTH need not be a power of two.
- Adds over the previous generation: selectable FWFT/standard read, runtime prog_full threshold, early flush on last, occupancy count, sticky overflow/underflow flags.
- Sits between the compute-group output and the memory write controller.

Parameters:
- LANES, COMPUTING_GROUP_SIZE, features per input beat
- ELEM_W, FEATURE_BIT_SIZE, bits per feature
- RATIO, 2, input beats per output word (>=1)
- DEPTH, WRITE_FIFO_SIZE + 1, output-word entries (>=2, any integer)
- FWFT, 1, 1 = first-word-fall-through read, 0 = registered read (dout valid 1 cycle after rd_en)
- derived: IN_W = LANES*ELEM_W; OUT_W = RATIO*IN_W; CNT_W = $clog2(DEPTH+1); BCNT_W = $clog2(RATIO+1)

Ports:
- clk  in  1  single clock, rising edge
- srst  in  1  synchronous, active-high reset
- din  in  IN_W  input beat
- din_last  in  1  qualifies din; closes current word after this beat
- wr_en  in  1  write request
- rd_en  in  1  read/pop request
- prog_thresh  in  CNT_W  prog_full threshold, sampled every cycle
- dout  out  OUT_W  packed word
- dout_beats  out  BCNT_W  valid input beats in dout (1..RATIO)
- full  out  1  store holds DEPTH words
- empty  out  1  no readable word
- prog_full  out  1  count >= prog_thresh
- count  out  CNT_W  words in store
- overflow  out  1  sticky: wr_en while full
- underflow  out  1  sticky: rd_en while empty

Behaviour:
- Reset (srst=1 on clock edge): pointers, pack counter and count go to 0. Pack register and dout go to 0. empty=1, full=0, dout_beats=0. overflow and underflow are cleared; srst is the only thing that clears them.
- prog_full follows count vs prog_thresh combinationally. prog_thresh=0 gives prog_full=1 after reset.
- Write accept: wr_en && !full. Beat k (0-based) goes to pack bits [k*IN_W +: IN_W]; first beat is least significant.
- Word push: on the accepted beat where k==RATIO-1 or din_last=1. The word is written to the store in that same edge. Unfilled slices are zero. dout_beats = k+1 is stored alongside. The pack counter returns to 0.
- full = (count == DEPTH), conservative, so any accepted beat always has a slot. Partial beats held in the pack register are not counted.
- wr_en while full: beat dropped, pack state unchanged, overflow set.
- Read accept: rd_en && !empty. rd_en while empty: no pointer change, dout unchanged, underflow set.
- FWFT=1: empty=(count==0). dout/dout_beats show the head word combinationally from the store. A pushed word is visible the cycle after its push edge. A pop advances the head on the edge.
- FWFT=0: dout/dout_beats are registered and load the head on an accepted read; valid the next cycle and held otherwise.
- Push and pop in the same cycle: count unchanged. This is legal at count==DEPTH only if wr_en is not blocked; since full blocks wr_en, push at full never occurs. Pop at count==0 never occurs.
- Pointers wrap from DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- srst mid-packing discards partial beats. srst has priority over wr_en/rd_en in the same cycle.
- RATIO=1: every accepted beat pushes; din_last is ignored; dout_beats is always 1.

Decomposition:
- definitions_pkg: COMPUTING_GROUP_SIZE, FEATURE_BIT_SIZE, WRITE_FIFO_SIZE (existing). Add CTRLWRITE_PACK_RATIO and a typedef for the {beats, data} store entry.
- One sub-module: fifo_ctrlwrite_store. It is a circular store with non-power-of-two wrap, count, and FWFT/registered read (parameters: WIDTH, DEPTH, FWFT). The top level holds the packer, full/prog_full logic and sticky flags.

Test Plan (LANES=2, ELEM_W=8, RATIO=2, DEPTH=5, FWFT=1 unless noted):
- Write 16'h1111, 16'h2222 (last=0) -> next cycle empty=0, dout=32'h2222_1111, dout_beats=2, count=1.
- Write 16'hAAAA with last=1 -> dout=32'h0000_AAAA, dout_beats=1. The next beat starts at slice 0.
- Write 10 beats (5 words), prog_thresh=4 -> prog_full rises at count=4, full=1 at count=5. An 11th wr_en is dropped, overflow=1 and stays 1, count=5.
- From full, pop 5 and push 3 words interleaved with simultaneous push+pop cycles -> data is FIFO-ordered across pointer wrap 4->0, and count tracks exactly.
- rd_en on empty -> underflow=1, dout unchanged. Then srst mid-pack (1 beat held) -> all outputs at reset values, and the held beat never appears.
- FWFT=0: push a word, assert rd_en -> dout valid exactly 1 cycle later and holds until the next accepted read.
